// File: rtl/stopwatch_pkg.sv
// Shared types and BCD helpers for the stopwatch timekeeping core.
// Holds the run-state enum, digit widths and the 00-59 field increment.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } sw_state_t;

    localparam int TENS_W  = 3;
    localparam int ONES_W  = 4;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef struct packed {
        logic [TENS_W-1:0] t;
        logic [ONES_W-1:0] o;
    } bcd_pair_t;

    typedef struct packed {
        bcd_pair_t mins;
        bcd_pair_t secs;
    } mmss_t;

    function automatic logic bcd_at_max(
        input bcd_pair_t v,
        input int        max
    );
        return (v.t == TENS_W'(max / 10)) &&
               (v.o == ONES_W'(max % 10));
    endfunction

    // Wraps to 00 at max; the caller decides whether that wrap carries.
    function automatic bcd_pair_t bcd_inc(
        input bcd_pair_t v,
        input int        max
    );
        bcd_pair_t r;
        r = v;
        if (bcd_at_max(v, max)) begin
            r = '0;
        end else if (v.o == ONES_W'(9)) begin
            r.t = v.t + TENS_W'(1);
            r.o = '0;
        end else begin
            r.o = v.o + ONES_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_counter_tick_sync.sv
// Synchroniser chain plus edge register for one slow divider output.
// rise is high for exactly one cycle per synchronised rising edge.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: run/pause/adjust state machine driven by
// synchronised divider ticks, with registered digits and blink blanking.
import stopwatch_pkg::*;

module stopwatch_counter #(
    parameter int SYNC_STAGES   = 2,
    parameter bit START_RUNNING = 1'b0
) (
    input  logic              clk_100MHz,
    input  logic              rst_n,
    input  logic              clk_1Hz,
    input  logic              clk_2Hz,
    input  logic              clk_adjust,
    input  logic              pause,
    input  logic              adj,
    input  logic              sel,
    output logic [TENS_W-1:0] min_t,
    output logic [ONES_W-1:0] min_o,
    output logic [TENS_W-1:0] sec_t,
    output logic [ONES_W-1:0] sec_o,
    output logic [3:0]        blank,
    output logic              running
);

    localparam sw_state_t RST_STATE = START_RUNNING ? RUN : PAUSED;

    logic tick_1hz;
    logic tick_2hz;
    logic blink_lvl;
    logic lvl_1hz_unused;
    logic lvl_2hz_unused;
    logic rise_adj_unused;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1hz (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .d          (clk_1Hz),
        .level      (lvl_1hz_unused),
        .rise       (tick_1hz)
    );

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_2hz (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .d          (clk_2Hz),
        .level      (lvl_2hz_unused),
        .rise       (tick_2hz)
    );

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adj (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .d          (clk_adjust),
        .level      (blink_lvl),
        .rise       (rise_adj_unused)
    );

    sw_state_t state_q;
    sw_state_t state_d;
    mmss_t     cnt_q;
    mmss_t     cnt_d;
    logic [3:0] blank_q;
    logic [3:0] blank_d;
    logic       run_q;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // adj dominates; pause only toggles between RUN and PAUSED.
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            adj: begin
                state_d = ADJUST;
            end
            !adj && (state_q == ADJUST): begin
                state_d = PAUSED;
            end
            !adj && pause && (state_q == RUN): begin
                state_d = PAUSED;
            end
            !adj && pause && (state_q == PAUSED): begin
                state_d = RUN;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Ticks are applied per the pre-transition state.
    always_comb begin
        cnt_d = cnt_q;
        unique case (state_q)
            RUN: begin
                if (tick_1hz) begin
                    cnt_d.secs = bcd_inc(cnt_q.secs, SEC_MAX);
                    if (bcd_at_max(cnt_q.secs, SEC_MAX)) begin
                        cnt_d.mins = bcd_inc(cnt_q.mins, MIN_MAX);
                    end
                end
            end
            ADJUST: begin
                if (tick_2hz) begin
                    if (sel) begin
                        cnt_d.secs = bcd_inc(cnt_q.secs, SEC_MAX);
                    end else begin
                        cnt_d.mins = bcd_inc(cnt_q.mins, MIN_MAX);
                    end
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase

        blank_d = '0;
        if (state_d == ADJUST) begin
            if (sel) begin
                blank_d = {2'b00, {2{blink_lvl}}};
            end else begin
                blank_d = {{2{blink_lvl}}, 2'b00};
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            blank_q <= '0;
            run_q   <= START_RUNNING;
        end else begin
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            run_q   <= (state_d == RUN);
        end
    end

    assign min_t   = cnt_q.mins.t;
    assign min_o   = cnt_q.mins.o;
    assign sec_t   = cnt_q.secs.t;
    assign sec_o   = cnt_q.secs.o;
    assign blank   = blank_q;
    assign running = run_q;

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Timekeeping core of the stopwatch, directly downstream of the clock divider. It consumes the divider's slow square-wave outputs (`clk_1Hz`, `clk_2Hz`, `clk_adjust`) as data, never as clocks. It synchronises them into the `clk_100MHz` domain and converts their rising edges into one-cycle ticks. From those ticks it maintains an MM:SS BCD count, 00:00–59:59, with run/pause and per-field adjust, and drives digit values plus blink-blanking to the seven-segment display driver.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth for each divider input; must be ≥ 2.
- `START_RUNNING`, default 0: 1 means the state after reset is RUN; 0 means PAUSED.

Ports:
- `clk_100MHz`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_1Hz`  in  1  divider output; each rising edge is one count event.
- `clk_2Hz`  in  1  divider output; each rising edge is one adjust step.
- `clk_adjust`  in  1  divider output; its level gates the blink.
- `pause`  in  1  single-cycle pulse, already debounced upstream; toggles RUN/PAUSED.
- `adj`  in  1  level; 1 selects ADJUST mode.
- `sel`  in  1  level; field to adjust, 0 = minutes, 1 = seconds.
- `min_t`  out  3  minutes tens digit, 0–5.
- `min_o`  out  4  minutes ones digit, 0–9.
- `sec_t`  out  3  seconds tens digit, 0–5.
- `sec_o`  out  4  seconds ones digit, 0–9.
- `blank`  out  4  per-digit blank, bit order {min_t, min_o, sec_t, sec_o}; 1 means the digit is dark.
- `running`  out  1  1 when the state is RUN.

## Operation
- **States:** RUN, PAUSED, ADJUST.
- **RUN:**
  - `pause` → PAUSED.
  - `adj` = 1 → ADJUST.
- **PAUSED:**
  - `pause` → RUN.
  - `adj` = 1 → ADJUST.
- **ADJUST:**
  - `adj` = 0 → PAUSED.
  - `pause` is ignored.
- **`adj` priority:** `adj` = 1 takes priority over `pause` in every state.
- **Tick generation:** each input passes through a `SYNC_STAGES` flop chain. A tick is the synchronised level high AND its previous sample low.
- **RUN, 1 Hz tick:**
  - `sec_o` increments.
  - 9 → 0 carries into `sec_t`; 5 → 0 carries into `min_o`; and so on up through `min_t`.
  - 59:59 → 00:00 wraps silently.
- **PAUSED:** all ticks are ignored.
- **ADJUST, 2 Hz tick:** the selected field increments as a 00–59 BCD pair.
  - 59 → 00 wraps with no carry into the other field.
  - 1 Hz ticks are ignored.
- **Blink:**
  - In ADJUST, the two `blank` bits of the selected field equal the synchronised `clk_adjust` level.
  - The other two `blank` bits are 0.
  - Outside ADJUST, `blank` = 0.
- **Same-cycle tick and state change:** the tick is applied according to the current (pre-transition) state. RUN + tick + `pause` → count increments AND state becomes PAUSED.
- **`sel` changing mid-ADJUST:** takes effect on the next 2 Hz tick; no carry and no count change result from the switch itself.
- **Reset:**
  - Digits 00:00.
  - `blank` = 0.
  - State PAUSED, or RUN if `START_RUNNING` = 1.
  - `running` matches the reset state.
  - Synchroniser and edge flops cleared to 0.
  - A divider input that is high at reset release produces at most one tick, applied per the reset state.
- **Reset mid-count:** asserting `rst_n` low clears everything immediately (asynchronous); there is no partial update.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- **Count latency:** digits change on the (`SYNC_STAGES` + 1)th `clk_100MHz` edge counting from the first edge that samples a divider input high. This is 3 edges with the default depth.
- **Pause latency:** `pause` sampled high at edge k → state and `running` change at edge k. A tick whose count update lands at edge k is still processed as RUN.
- **`adj` latency:** `adj` is used unsynchronised by this block, since upstream delivers it already synchronised. State changes on the first edge sampling the new level.
- **Blink latency:** `blank` follows `clk_adjust` with `SYNC_STAGES` + 1 cycles of latency.

## Structure
- **Shared package `stopwatch_pkg`:**
  - State enum `sw_state_t` {RUN, PAUSED, ADJUST}.
  - Constants `SEC_MAX` = 59 and `MIN_MAX` = 59.
  - BCD digit widths.
- **Sub-module `tick_sync`:**
  - Parameterised `SYNC_STAGES` flop chain plus edge register.
  - Outputs `level` and `rise`.
  - Instantiated three times, for `clk_1Hz`, `clk_2Hz` and `clk_adjust`.
- The BCD 00–59 field-increment logic is a function in the package, shared by the count and adjust paths.

## Test plan
- **Reset/run:** `rst_n` low, `START_RUNNING` = 0, release, one `pause` pulse, 5 `clk_1Hz` rising edges → digits 00:05, `running` = 1, `blank` = 0000; each change lands 3 cycles after the edge.
- **Rollover:** preload 59:58 via ADJUST, exit, run, 2 `clk_1Hz` edges → 59:59, then 00:00; carries visible at 00:09 → 00:10 and 00:59 → 01:00.
- **Adjust no-carry:** `adj` = 1, `sel` = 1, count at 00:58, 3 `clk_2Hz` edges → 00:59, 00:00, 00:01, with minutes unchanged. Then `sel` = 0, 60 edges → minutes cycle back to 00.
- **Blink and ignore:** in ADJUST with `sel` = 0, toggle `clk_adjust` → `blank` alternates 1100/0000. Issue `pause` pulses and `clk_1Hz` edges → no state or count change. Drop `adj` → PAUSED, `blank` = 0000.
- **Simultaneous:** in RUN, align a `pause` pulse with the count-update cycle of a 1 Hz tick → count increments by exactly 1, `running` = 0 at that same edge.
- **Mid-op reset:** at 12:34 in RUN, pulse `rst_n` low for 1 ns between clock edges → digits 00:00 and state PAUSED immediately; with `clk_1Hz` held high at release → no more than one increment, and in PAUSED that increment is dropped.
